brick_game_controller: RTL and testbench

BRICK_GAME_CONTROLLER -- requirements
Module: brick_game_controller

---
 rtl/brick_game_controller.sv | 187 ++++++++++++++++++
 tb/tb_brick_game_controller.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/brick_game_controller.sv
// brick_game_controller: game sequencer for a brick-breaker.
// It tracks which bricks are still alive and queues collision requests.
// It removes one brick per cycle, lowest index first, and keeps a BCD score.
// It runs the IDLE/SERVE/PLAY/PAUSED/WON/LOST flow and drives the ball and
// paddle motion enables. All outputs come straight from registers.
module brick_game_controller #(
  parameter int          NUM_BRICKS = 6,
  parameter int          LIVES_INIT = 3,
  // BCD score loaded at reset and at each new game (normally 0000)
  parameter logic [15:0] SCORE_INIT = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pause,
  input  logic [NUM_BRICKS-1:0] brick_hit,
  input  logic                  ball_lost,
  output logic [NUM_BRICKS-1:0] brick_alive,
  output logic [NUM_BRICKS-1:0] hit_ack,
  output logic [2:0]            game_state,
  output logic [3:0]            thous,
  output logic [3:0]            huns,
  output logic [3:0]            tens,
  output logic [3:0]            ones,
  output logic [1:0]            lives,
  output logic                  ball_enable,
  output logic                  board_enable
);

  localparam logic [1:0] LIVES_RST = 2'(LIVES_INIT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SERVE  = 3'd1,
    S_PLAY   = 3'd2,
    S_PAUSED = 3'd3,
    S_WON    = 3'd4,
    S_LOST   = 3'd5
  } state_t;

  state_t                state_reg, state_next;
  logic                  start_prev_reg;
  logic [NUM_BRICKS-1:0] pending_reg, pending_next;
  logic [NUM_BRICKS-1:0] alive_reg, alive_next;
  logic [NUM_BRICKS-1:0] hit_ack_reg;
  logic [15:0]           score_reg, score_next;
  logic [1:0]            lives_reg, lives_next;
  logic                  ball_en_reg, board_en_reg;

  logic                  start_edge;
  logic                  grant_en;
  logic                  any_grant;
  logic                  last_cleared;
  logic [NUM_BRICKS-1:0] grant_raw;
  logic [NUM_BRICKS-1:0] grant;
  logic [NUM_BRICKS-1:0] alive_after;
  logic [NUM_BRICKS:0]   lower_pending;

  // A held button produces a single event: only the 0->1 step counts.
  assign start_edge = start & ~start_prev_reg;

  // Fixed-priority pick: a pending bit wins only if no lower bit is pending.
  assign lower_pending[0] = 1'b0;
  for (genvar gi = 0; gi < NUM_BRICKS; gi++) begin : g_prio
    assign grant_raw[gi]        = pending_reg[gi] & ~lower_pending[gi];
    assign lower_pending[gi+1]  = lower_pending[gi] | pending_reg[gi];
  end

  // Queued hits keep draining while paused or waiting to serve.
  assign grant_en     = (state_reg == S_PLAY) || (state_reg == S_PAUSED) ||
                        (state_reg == S_SERVE);
  assign grant        = grant_en ? grant_raw : '0;
  assign any_grant    = grant_en & lower_pending[NUM_BRICKS];
  assign alive_after  = alive_reg & ~grant;
  assign last_cleared = any_grant && (alive_after == '0);

  // BCD +1 with digit carry; the score sticks at 9999.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v == 16'h9999) return v;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Next-state and datapath update.
  // Clearing the last brick outranks pause and ball_lost.
  always_comb begin
    state_next   = state_reg;
    lives_next   = lives_reg;
    pending_next = pending_reg & ~grant;
    alive_next   = alive_after;
    score_next   = any_grant ? bcd_inc(score_reg) : score_reg;
    case (state_reg)
      S_IDLE: begin
        if (start_edge) state_next = S_PLAY;
      end
      S_PLAY: begin
        // The brick granted this cycle is already dead and must not re-queue.
        pending_next = pending_next | (brick_hit & alive_after);
        if (last_cleared) begin
          state_next = S_WON;
        end else if (pause) begin
          state_next = S_PAUSED;
        end else if (ball_lost) begin
          if (lives_reg > 2'd1) begin
            state_next = S_SERVE;
            lives_next = lives_reg - 2'd1;
          end else begin
            state_next = S_LOST;
            lives_next = 2'd0;
          end
        end
      end
      S_PAUSED: begin
        if (last_cleared)  state_next = S_WON;
        else if (!pause)   state_next = S_PLAY;
      end
      S_SERVE: begin
        if (last_cleared)              state_next = S_WON;
        else if (start_edge && !pause) state_next = S_PLAY;
      end
      S_WON, S_LOST: begin
        if (start_edge) begin
          state_next   = S_IDLE;
          alive_next   = '1;
          pending_next = '0;
          score_next   = SCORE_INIT;
          lives_next   = LIVES_RST;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= S_IDLE;
    else      state_reg <= state_next;
  end

  // Datapath registers. The enables follow the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_prev_reg <= 1'b0;
      pending_reg    <= '0;
      alive_reg      <= '1;
      hit_ack_reg    <= '0;
      score_reg      <= SCORE_INIT;
      lives_reg      <= LIVES_RST;
      ball_en_reg    <= 1'b0;
      board_en_reg   <= 1'b0;
    end else begin
      start_prev_reg <= start;
      pending_reg    <= pending_next;
      alive_reg      <= alive_next;
      hit_ack_reg    <= grant;
      score_reg      <= score_next;
      lives_reg      <= lives_next;
      ball_en_reg    <= (state_next == S_PLAY);
      board_en_reg   <= (state_next == S_PLAY) || (state_next == S_SERVE);
    end
  end

  assign brick_alive  = alive_reg;
  assign hit_ack      = hit_ack_reg;
  assign game_state   = state_reg;
  assign thous        = score_reg[15:12];
  assign huns         = score_reg[11:8];
  assign tens         = score_reg[7:4];
  assign ones         = score_reg[3:0];
  assign lives        = lives_reg;
  assign ball_enable  = ball_en_reg;
  assign board_enable = board_en_reg;

endmodule

// File: tb/tb_brick_game_controller.sv
// Scoreboard bench for brick_game_controller.
// Three instances share the stimulus. Instance a uses the default score
// preload. Instances b and c preload 0099 and 9999 to exercise BCD carry
// and saturation.
module tb_brick_game_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       ball_lost = 1'b0;
  logic [5:0] brick_hit = 6'b0;

  logic [5:0] alive_a, ack_a, alive_b, ack_b, alive_c, ack_c;
  logic [2:0] st_a, st_b, st_c;
  logic [3:0] th_a, hu_a, te_a, on_a, th_b, hu_b, te_b, on_b, th_c, hu_c, te_c, on_c;
  logic [1:0] lv_a, lv_b, lv_c;
  logic       be_a, bd_a, be_b, bd_b, be_c, bd_c;
  logic [15:0] score_a, score_b, score_c;

  assign score_a = {th_a, hu_a, te_a, on_a};
  assign score_b = {th_b, hu_b, te_b, on_b};
  assign score_c = {th_c, hu_c, te_c, on_c};

  always #5 clk = ~clk;

  brick_game_controller dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .brick_hit(brick_hit),
    .ball_lost(ball_lost), .brick_alive(alive_a), .hit_ack(ack_a), .game_state(st_a),
    .thous(th_a), .huns(hu_a), .tens(te_a), .ones(on_a), .lives(lv_a),
    .ball_enable(be_a), .board_enable(bd_a));

  brick_game_controller #(.SCORE_INIT(16'h0099)) dut_b (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .brick_hit(brick_hit),
    .ball_lost(ball_lost), .brick_alive(alive_b), .hit_ack(ack_b), .game_state(st_b),
    .thous(th_b), .huns(hu_b), .tens(te_b), .ones(on_b), .lives(lv_b),
    .ball_enable(be_b), .board_enable(bd_b));

  brick_game_controller #(.SCORE_INIT(16'h9999)) dut_c (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .brick_hit(brick_hit),
    .ball_lost(ball_lost), .brick_alive(alive_c), .hit_ack(ack_c), .game_state(st_c),
    .thous(th_c), .huns(hu_c), .tens(te_c), .ones(on_c), .lives(lv_c),
    .ball_enable(be_c), .board_enable(bd_c));

  typedef struct {
    logic [5:0]  ack;
    logic [5:0]  alive;
    logic [15:0] sa;
    logic [15:0] sb;
    logic [15:0] sc;
  } grant_t;

  typedef struct {
    logic [2:0]  st;
    logic [1:0]  lv;
    logic        be;
    logic        bd;
    logic [5:0]  alive;
    logic [15:0] sa;
  } state_exp_t;

  grant_t     gq[$];
  state_exp_t sq[$];

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic exp_grant(input logic [5:0] ack, input logic [5:0] alive,
                           input logic [15:0] sa, input logic [15:0] sb, input logic [15:0] sc);
    grant_t g;
    g = '{ack, alive, sa, sb, sc};
    gq.push_back(g);
  endtask

  task automatic exp_state(input logic [2:0] st, input logic [1:0] lv, input logic be,
                           input logic bd, input logic [5:0] alive, input logic [15:0] sa);
    state_exp_t s;
    s = '{st, lv, be, bd, alive, sa};
    sq.push_back(s);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic pulse_lost();
    ball_lost = 1'b1;
    cyc(1);
    ball_lost = 1'b0;
  endtask

  // Monitor: pops an expectation whenever a grant pulse or a state change appears.
  initial begin : monitor
    grant_t     g;
    state_exp_t s;
    logic [2:0] last_st;
    last_st = 3'd0;
    wait (rst === 1'b1);
    forever begin
      @(negedge clk);
      if (ack_a !== 6'b0) begin
        if (gq.size() == 0) begin
          chk("unexpected_hit_ack", 32'(ack_a), 32'd0);
        end else begin
          g = gq.pop_front();
          $display("grant ack=%b alive=%b score=%h/%h/%h", ack_a, alive_a, score_a, score_b, score_c);
          chk("hit_ack_a", 32'(ack_a), 32'(g.ack));
          chk("hit_ack_b", 32'(ack_b), 32'(g.ack));
          chk("hit_ack_c", 32'(ack_c), 32'(g.ack));
          chk("grant_alive", 32'(alive_a), 32'(g.alive));
          chk("score_a", 32'(score_a), 32'(g.sa));
          chk("score_b", 32'(score_b), 32'(g.sb));
          chk("score_c", 32'(score_c), 32'(g.sc));
        end
      end
      if (st_a !== last_st) begin
        if (sq.size() == 0) begin
          chk("unexpected_state", 32'(st_a), 32'(last_st));
        end else begin
          s = sq.pop_front();
          $display("state %0d lives=%0d ball=%b board=%b alive=%b score=%h", st_a, lv_a, be_a, bd_a, alive_a, score_a);
          chk("state_a", 32'({st_a, lv_a, be_a, bd_a, alive_a}), 32'({s.st, s.lv, s.be, s.bd, s.alive}));
          chk("state_b", 32'({st_b, lv_b, be_b, bd_b, alive_b}), 32'({s.st, s.lv, s.be, s.bd, s.alive}));
          chk("state_c", 32'({st_c, lv_c, be_c, bd_c, alive_c}), 32'({s.st, s.lv, s.be, s.bd, s.alive}));
          chk("state_score", 32'(score_a), 32'(s.sa));
        end
        last_st = st_a;
      end
    end
  end

  // Directed stimulus with hand-computed expectations.
  initial begin : stimulus
    cyc(2);
    chk("rst_state", 32'(st_a), 32'd0);
    chk("rst_alive", 32'(alive_a), 32'h3f);
    chk("rst_hit_ack", 32'(ack_a), 32'd0);
    chk("rst_score_a", 32'(score_a), 32'h0000);
    chk("rst_score_b", 32'(score_b), 32'h0099);
    chk("rst_score_c", 32'(score_c), 32'h9999);
    chk("rst_lives", 32'(lv_a), 32'd3);
    chk("rst_ball_en", 32'(be_a), 32'd0);
    chk("rst_board_en", 32'(bd_a), 32'd0);
    rst = 1'b1;
    cyc(2);

    // Single hit two edges after request, with carry and saturation on b/c.
    exp_state(3'd2, 2'd3, 1'b1, 1'b1, 6'b111111, 16'h0000);
    pulse_start();
    brick_hit = 6'b000100;
    exp_grant(6'b000100, 6'b111011, 16'h0001, 16'h0100, 16'h9999);
    cyc(1);
    brick_hit = 6'b0;
    cyc(4);

    // Three simultaneous hits drain lowest index first.
    brick_hit = 6'b101001;
    exp_grant(6'b000001, 6'b111010, 16'h0002, 16'h0101, 16'h9999);
    exp_grant(6'b001000, 6'b110010, 16'h0003, 16'h0102, 16'h9999);
    exp_grant(6'b100000, 6'b010010, 16'h0004, 16'h0103, 16'h9999);
    cyc(1);
    brick_hit = 6'b0;
    cyc(6);

    // Pause with a hit pending (dead brick 2 dropped); grant completes while paused.
    brick_hit = 6'b000110;
    pause = 1'b1;
    exp_state(3'd3, 2'd3, 1'b0, 1'b0, 6'b010010, 16'h0004);
    exp_grant(6'b000010, 6'b010000, 16'h0005, 16'h0104, 16'h9999);
    cyc(1);
    brick_hit = 6'b0;
    cyc(2);
    brick_hit = 6'b010000;
    cyc(1);
    brick_hit = 6'b0;
    cyc(2);
    pause = 1'b0;
    exp_state(3'd2, 2'd3, 1'b1, 1'b1, 6'b010000, 16'h0005);
    cyc(3);

    // Last brick cleared on the same edge as ball_lost: WON wins, lives kept.
    brick_hit = 6'b010000;
    exp_grant(6'b010000, 6'b000000, 16'h0006, 16'h0105, 16'h9999);
    exp_state(3'd4, 2'd3, 1'b0, 1'b0, 6'b000000, 16'h0006);
    cyc(1);
    brick_hit = 6'b0;
    pulse_lost();
    cyc(3);

    // New game reload.
    exp_state(3'd0, 2'd3, 1'b0, 1'b0, 6'b111111, 16'h0000);
    pulse_start();
    cyc(3);
    chk("reload_score_b", 32'(score_b), 32'h0099);
    chk("reload_score_c", 32'(score_c), 32'h9999);

    // Lose all lives.
    exp_state(3'd2, 2'd3, 1'b1, 1'b1, 6'b111111, 16'h0000);
    pulse_start();
    cyc(2);
    exp_state(3'd1, 2'd2, 1'b0, 1'b1, 6'b111111, 16'h0000);
    pulse_lost();
    cyc(2);
    pulse_lost();            // ignored in SERVE
    cyc(2);
    pause = 1'b1;
    pulse_start();           // blocked by pause in SERVE
    cyc(2);
    pause = 1'b0;
    cyc(1);
    exp_state(3'd2, 2'd2, 1'b1, 1'b1, 6'b111111, 16'h0000);
    pulse_start();
    cyc(2);
    exp_state(3'd1, 2'd1, 1'b0, 1'b1, 6'b111111, 16'h0000);
    pulse_lost();
    cyc(2);
    exp_state(3'd2, 2'd1, 1'b1, 1'b1, 6'b111111, 16'h0000);
    pulse_start();
    cyc(2);
    exp_state(3'd5, 2'd0, 1'b0, 1'b0, 6'b111111, 16'h0000);
    pulse_lost();
    cyc(2);
    // Held start: exactly one event (LOST -> IDLE, not on to PLAY).
    exp_state(3'd0, 2'd3, 1'b0, 1'b0, 6'b111111, 16'h0000);
    start = 1'b1;
    cyc(4);
    start = 1'b0;
    cyc(2);

    // Reset mid-game discards a pending grant.
    exp_state(3'd2, 2'd3, 1'b1, 1'b1, 6'b111111, 16'h0000);
    pulse_start();
    cyc(2);
    brick_hit = 6'b000001;
    cyc(1);
    brick_hit = 6'b0;
    exp_state(3'd0, 2'd3, 1'b0, 1'b0, 6'b111111, 16'h0000);
    rst = 1'b0;
    cyc(1);
    rst = 1'b1;
    cyc(3);
    exp_state(3'd2, 2'd3, 1'b1, 1'b1, 6'b111111, 16'h0000);
    pulse_start();
    cyc(4);
    chk("post_reset_alive", 32'(alive_a), 32'h3f);
    chk("post_reset_score", 32'(score_a), 32'h0000);

    cyc(3);
    chk("grant_queue_drained", 32'(gq.size()), 32'd0);
    chk("state_queue_drained", 32'(sq.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
